// File: rtl/idct_block_sched.sv
// idct_block_sched: time-multiplexed 8x8 Chen-Wang IDCT (one row unit, one column unit,
// 64-entry transpose buffer). Define IDCT_ROW_SKIP_EN to skip all-zero rows in the ROW pass.

module idctrow #(
  parameter int ML = 16
) (
  input  logic signed [ML-1:0] blk_i [8],
  output logic signed [ML-1:0] blk_o [8]
);
  localparam int W1 = 2841, W2 = 2676, W3 = 2408, W5 = 1609, W6 = 1108, W7 = 565;
  int x0, x1, x2, x3, x4, x5, x6, x7, x8;

  always_comb begin
    x0 = (int'(blk_i[0]) <<< 11) + 128;
    x1 = int'(blk_i[4]) <<< 11;
    x2 = int'(blk_i[6]);
    x3 = int'(blk_i[2]);
    x4 = int'(blk_i[1]);
    x5 = int'(blk_i[7]);
    x6 = int'(blk_i[5]);
    x7 = int'(blk_i[3]);
    x8 = W7 * (x4 + x5);
    x4 = x8 + (W1 - W7) * x4;
    x5 = x8 - (W1 + W7) * x5;
    x8 = W3 * (x6 + x7);
    x6 = x8 - (W3 - W5) * x6;
    x7 = x8 - (W3 + W5) * x7;
    x8 = x0 + x1;
    x0 = x0 - x1;
    x1 = W6 * (x3 + x2);
    x2 = x1 - (W2 + W6) * x2;
    x3 = x1 + (W2 - W6) * x3;
    x1 = x4 + x6;
    x4 = x4 - x6;
    x6 = x5 + x7;
    x5 = x5 - x7;
    x7 = x8 + x3;
    x8 = x8 - x3;
    x3 = x0 + x2;
    x0 = x0 - x2;
    x2 = (181 * (x4 + x5) + 128) >>> 8;
    x4 = (181 * (x4 - x5) + 128) >>> 8;
    blk_o[0] = ML'((x7 + x1) >>> 8);
    blk_o[1] = ML'((x3 + x2) >>> 8);
    blk_o[2] = ML'((x0 + x4) >>> 8);
    blk_o[3] = ML'((x8 + x6) >>> 8);
    blk_o[4] = ML'((x8 - x6) >>> 8);
    blk_o[5] = ML'((x0 - x4) >>> 8);
    blk_o[6] = ML'((x3 - x2) >>> 8);
    blk_o[7] = ML'((x7 - x1) >>> 8);
  end
endmodule

module idctcol #(
  parameter int ML = 16
) (
  input  logic signed [ML-1:0] blk_i [8],
  output logic signed [ML-1:0] blk_o [8]
);
  localparam int W1 = 2841, W2 = 2676, W3 = 2408, W5 = 1609, W6 = 1108, W7 = 565;
  int x0, x1, x2, x3, x4, x5, x6, x7, x8;

  // Final pixel range is [-256, 255].
  function automatic logic signed [ML-1:0] clip(input int v);
    if (v < -256) return ML'(-256);
    if (v > 255) return ML'(255);
    return ML'(v);
  endfunction

  always_comb begin
    x0 = (int'(blk_i[0]) <<< 8) + 8192;
    x1 = int'(blk_i[4]) <<< 8;
    x2 = int'(blk_i[6]);
    x3 = int'(blk_i[2]);
    x4 = int'(blk_i[1]);
    x5 = int'(blk_i[7]);
    x6 = int'(blk_i[5]);
    x7 = int'(blk_i[3]);
    x8 = W7 * (x4 + x5) + 4;
    x4 = (x8 + (W1 - W7) * x4) >>> 3;
    x5 = (x8 - (W1 + W7) * x5) >>> 3;
    x8 = W3 * (x6 + x7) + 4;
    x6 = (x8 - (W3 - W5) * x6) >>> 3;
    x7 = (x8 - (W3 + W5) * x7) >>> 3;
    x8 = x0 + x1;
    x0 = x0 - x1;
    x1 = W6 * (x3 + x2) + 4;
    x2 = (x1 - (W2 + W6) * x2) >>> 3;
    x3 = (x1 + (W2 - W6) * x3) >>> 3;
    x1 = x4 + x6;
    x4 = x4 - x6;
    x6 = x5 + x7;
    x5 = x5 - x7;
    x7 = x8 + x3;
    x8 = x8 - x3;
    x3 = x0 + x2;
    x0 = x0 - x2;
    x2 = (181 * (x4 + x5) + 128) >>> 8;
    x4 = (181 * (x4 - x5) + 128) >>> 8;
    blk_o[0] = clip((x7 + x1) >>> 14);
    blk_o[1] = clip((x3 + x2) >>> 14);
    blk_o[2] = clip((x0 + x4) >>> 14);
    blk_o[3] = clip((x8 + x6) >>> 14);
    blk_o[4] = clip((x8 - x6) >>> 14);
    blk_o[5] = clip((x0 - x4) >>> 14);
    blk_o[6] = clip((x3 - x2) >>> 14);
    blk_o[7] = clip((x7 - x1) >>> 14);
  end
endmodule

module idct_block_sched #(
  parameter int ML     = 16,
  parameter int BUF_AW = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [ML-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [ML-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic [1:0]           phase
);
  localparam logic [1:0] S_LOAD = 2'd0, S_ROW = 2'd1, S_COL = 2'd2, S_DRAIN = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [BUF_AW-1:0]   cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          ac_nz_q, ac_nz_d;
  logic signed [ML-1:0] out_data_q, out_data_d;
  logic signed [ML-1:0] mem_q [1<<BUF_AW];
  logic signed [ML-1:0] mem_d [1<<BUF_AW];
  logic signed [ML-1:0] row_in [8], row_out [8], col_in [8], col_out [8];
`ifdef IDCT_ROW_SKIP_EN
  logic [7:0]          dc_nz_q, dc_nz_d;
  logic [7:0]          live_d, live_q, above;

  function automatic logic [2:0] low_idx(input logic [7:0] m);
    low_idx = 3'd0;
    for (int k = 7; k >= 0; k--) if (m[k]) low_idx = 3'(k);
  endfunction
`endif

  idctrow #(.ML(ML)) u_row (.blk_i(row_in), .blk_o(row_out));
  idctcol #(.ML(ML)) u_col (.blk_i(col_in), .blk_o(col_out));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      cnt_q      <= '0;
      idx_q      <= '0;
      ac_nz_q    <= '0;
      out_data_q <= '0;
`ifdef IDCT_ROW_SKIP_EN
      dc_nz_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ac_nz_q    <= ac_nz_d;
      out_data_q <= out_data_d;
`ifdef IDCT_ROW_SKIP_EN
      dc_nz_q    <= dc_nz_d;
`endif
    end
    mem_q <= mem_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ac_nz_d = ac_nz_q;
`ifdef IDCT_ROW_SKIP_EN
    dc_nz_d = dc_nz_q;
    live_q  = ac_nz_q | dc_nz_q;
    above   = live_q & (8'hFE << idx_q);
`endif
    case (state_q)
      S_LOAD: if (in_valid) begin
        // Beat 0 starts a new block, so the row flags restart from clear.
        if (cnt_q == '0) ac_nz_d = '0;
`ifdef IDCT_ROW_SKIP_EN
        if (cnt_q == '0) dc_nz_d = '0;
        if (in_data != '0 && cnt_q[2:0] == 3'd0) dc_nz_d[cnt_q[5:3]] = 1'b1;
`endif
        if (in_data != '0 && cnt_q[2:0] != 3'd0) ac_nz_d[cnt_q[5:3]] = 1'b1;
        cnt_d = cnt_q + BUF_AW'(1);
        if (cnt_q == '1) begin
`ifdef IDCT_ROW_SKIP_EN
          live_d  = ac_nz_d | dc_nz_d;
          state_d = (live_d != '0) ? S_ROW : S_COL;
          idx_d   = low_idx(live_d);
`else
          state_d = S_ROW;
          idx_d   = 3'd0;
`endif
        end
      end
      S_ROW: begin
`ifdef IDCT_ROW_SKIP_EN
        state_d = (above != '0) ? S_ROW : S_COL;
        idx_d   = low_idx(above);
`else
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_COL;
`endif
      end
      S_COL: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_DRAIN;
      end
      default: if (out_ready) begin
        cnt_d = cnt_q + BUF_AW'(1);
        if (cnt_q == '1) state_d = S_LOAD;
      end
    endcase
  end

`ifndef IDCT_ROW_SKIP_EN
  logic [7:0] live_d_unused;
  assign live_d_unused = '0;
`endif

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      row_in[k] = mem_q[{idx_q, 3'(k)}];
      col_in[k] = mem_q[{3'(k), idx_q}];
    end
  end

  always_comb begin
    mem_d      = mem_q;
    out_data_d = out_data_q;
    case (state_q)
      S_LOAD: if (in_valid) mem_d[cnt_q] = in_data;
      S_ROW: begin
        // DC-only rows bypass the row unit: every output is i0<<3.
        for (int k = 0; k < 8; k++)
          mem_d[{idx_q, 3'(k)}] = ac_nz_q[idx_q] ? row_out[k] : (row_in[0] <<< 3);
      end
      S_COL: begin
        for (int k = 0; k < 8; k++) mem_d[{3'(k), idx_q}] = col_out[k];
        if (idx_q == 3'd7) out_data_d = mem_q[0];
      end
      default: if (out_ready) out_data_d = mem_q[cnt_q + BUF_AW'(1)];
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    out_valid = (state_q == S_DRAIN);
    out_last  = (state_q == S_DRAIN) && (cnt_q == '1);
    busy      = !((state_q == S_LOAD) && (cnt_q == '0));
    phase     = state_q;
    out_data  = out_data_q;
  end
endmodule
